// File: rtl/jtag_scan_master_if.sv
// Command/response bundle for jtag_scan_master: one scan command in, one captured word out.
// The master modport is the command issuer; the slave modport is the scan engine.
interface jtag_scan_master_if #(
    parameter int unsigned MAX_LEN = 320,
    parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_type;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_scan_master.sv
// Command-driven JTAG master: walks the TAP from Run-Test/Idle through an IR/DR scan or a
// TAP reset, shifting the payload LSB first and capturing TDO on each TCK rising edge.
module jtag_scan_master #(
    parameter int unsigned MAX_LEN = 320,
    parameter int unsigned HALF    = 1,
    parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                   CK,
    input  logic                   TRST,
    jtag_scan_master_if.slave      bus,
    output logic                   busy,
    output logic                   tck_o,
    output logic                   tms_o,
    output logic                   tdi_o,
    input  logic                   tdo_i
);
    localparam int unsigned PW = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
    localparam logic [PW-1:0] PhRise = PW'(HALF - 1);
    localparam logic [PW-1:0] PhLast = PW'(2 * HALF - 1);
    localparam logic [1:0] TypReset = 2'd0;
    localparam logic [1:0] TypIr    = 2'd1;

    typedef enum logic [2:0] {StIdle, StHead, StShift, StTail, StResp} state_e;

    state_e             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic [PW-1:0]      ph_q, ph_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;

    logic active;
    logic tick_end;
    logic head_last;
    logic head_tms;

    always_ff @(posedge CK) begin
        if (TRST) begin
            state_q <= StIdle;
            type_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ph_q    <= '0;
            data_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
        end
    end

    // Header shape per command type; the reset walk is just a longer header with no payload.
    always_comb begin
        head_last = 1'b0;
        head_tms  = 1'b1;
        case (type_q)
            TypReset: begin
                head_last = (idx_q == LW'(5));
                head_tms  = (idx_q != LW'(5));
            end
            TypIr: begin
                head_last = (idx_q == LW'(3));
                head_tms  = (idx_q < LW'(2));
            end
            default: begin
                head_last = (idx_q == LW'(2));
                head_tms  = (idx_q == LW'(0));
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        len_d   = len_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        data_d  = data_q;
        cap_d   = cap_q;

        active   = (state_q == StHead) || (state_q == StShift) || (state_q == StTail);
        tick_end = (ph_q == PhLast);
        tck_o    = active && (ph_q > PhRise);
        tms_o    = 1'b1;
        tdi_o    = 1'b0;

        busy          = (state_q != StIdle);
        bus.cmd_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_data  = cap_q;

        if (active) begin
            ph_d = tick_end ? '0 : ph_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    type_d = (bus.cmd_type == 2'd3) ? TypReset : bus.cmd_type;
                    if (bus.cmd_len == '0) begin
                        len_d = LW'(1);
                    end else if (bus.cmd_len > LW'(MAX_LEN)) begin
                        len_d = LW'(MAX_LEN);
                    end else begin
                        len_d = bus.cmd_len;
                    end
                    data_d  = bus.cmd_data;
                    cap_d   = '0;
                    idx_d   = '0;
                    ph_d    = '0;
                    state_d = StHead;
                end
            end
            StHead: begin
                tms_o = head_tms;
                if (tick_end) begin
                    if (head_last) begin
                        idx_d   = '0;
                        state_d = (type_q == TypReset) ? StResp : StShift;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StShift: begin
                tms_o = (idx_q == len_q - 1'b1);
                tdi_o = data_q[idx_q];
                // This edge is the one that raises TCK.
                if (ph_q == PhRise) begin
                    cap_d[idx_q] = tdo_i;
                end
                if (tick_end) begin
                    if (idx_q == len_q - 1'b1) begin
                        idx_d   = '0;
                        state_d = StTail;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StTail: begin
                tms_o = (idx_q == LW'(0));
                if (tick_end) begin
                    if (idx_q == LW'(1)) begin
                        idx_d   = '0;
                        state_d = StResp;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench for jtag_scan_master: random scans against a tick-list reference model,
// with TDO supplied from a cycle-indexed random pattern so capture timing is predictable.
module tb_jtag_scan_master;
    localparam int ML  = 320;
    localparam int H   = 2;
    localparam int LWB = $clog2(ML + 1);
    localparam int W   = ML + 16;

    typedef struct {
        logic [W-1:0] rsp;
        logic [W-1:0] tms;
        logic [W-1:0] tdi;
        int           n;
        int           vcyc;
    } exp_t;

    logic clk;
    logic trst;
    logic busy, tck_o, tms_o, tdi_o, tdo_i;

    jtag_scan_master_if #(.MAX_LEN(ML), .LW(LWB)) bus ();

    jtag_scan_master #(.MAX_LEN(ML), .HALF(H), .LW(LWB)) dut (
        .CK    (clk),
        .TRST  (trst),
        .bus   (bus),
        .busy  (busy),
        .tck_o (tck_o),
        .tms_o (tms_o),
        .tdi_o (tdi_o),
        .tdo_i (tdo_i)
    );

    int   n_chk;
    int   n_pass;
    int   cyc;
    int   rsp_hold;
    bit   tdo_pat [65536];
    exp_t exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // TDO for the edge whose pre-edge cycle count is k is tdo_pat[k].
    initial begin
        for (int i = 0; i < 65536; i++) tdo_pat[i] = 1'($urandom);
        tdo_i = 1'b0;
        forever begin
            @(negedge clk);
            tdo_i = tdo_pat[cyc % 65536];
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // Reference: the TAP walk as a list of ticks, plus which cycle each TDO sample lands on.
    function automatic exp_t model(input logic [1:0] typ, input int len,
                                   input logic [ML-1:0] data, input int t);
        exp_t e;
        int   l;
        int   hdr;
        e.rsp = '0;
        e.tms = '0;
        e.tdi = '0;
        if (typ == 2'd0 || typ == 2'd3) begin
            for (int i = 0; i < 5; i++) e.tms[i] = 1'b1;
            e.n = 6;
        end else begin
            l   = (len == 0) ? 1 : ((len > ML) ? ML : len);
            hdr = (typ == 2'd1) ? 4 : 3;
            e.tms[0] = 1'b1;
            if (typ == 2'd1) e.tms[1] = 1'b1;
            for (int i = 0; i < l; i++) begin
                e.tms[hdr + i] = (i == l - 1);
                e.tdi[hdr + i] = data[i];
                e.rsp[i]       = tdo_pat[(t + (hdr + i) * 2 * H + H) % 65536];
            end
            e.tms[hdr + l] = 1'b1;
            e.n = hdr + l + 2;
        end
        e.vcyc = t + e.n * 2 * H + 1;
        return e;
    endfunction

    initial begin
        int wcnt;
        bus.rsp_ready = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                bus.rsp_ready = (wcnt >= rsp_hold);
                wcnt++;
            end else begin
                bus.rsp_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: records ticks at each TCK rise and checks every response against the queue head.
    initial begin
        logic [W-1:0] obs_tms;
        logic [W-1:0] obs_tdi;
        int   obs_n;
        int   stab_err;
        bit   tck_prev;
        bit   in_resp;
        exp_t cur;
        obs_tms = '0; obs_tdi = '0; obs_n = 0; stab_err = 0; tck_prev = 0; in_resp = 0;
        cur.rsp = '0; cur.tms = '0; cur.tdi = '0; cur.n = 0; cur.vcyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                obs_tms = '0; obs_tdi = '0; obs_n = 0; stab_err = 0; in_resp = 0;
            end
            if (tck_o && !tck_prev && obs_n < W) begin
                obs_tms[obs_n] = tms_o;
                obs_tdi[obs_n] = tdi_o;
                obs_n++;
            end else if (tck_o && tck_prev && obs_n > 0) begin
                if (tms_o !== obs_tms[obs_n - 1] || tdi_o !== obs_tdi[obs_n - 1]) stab_err++;
            end
            tck_prev = tck_o;
            if (bus.rsp_valid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", W'(1), W'(0));
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_data", W'(bus.rsp_data), cur.rsp);
                        chk("rsp_valid_cycle", W'(cyc), W'(cur.vcyc));
                        chk("tick_count", W'(obs_n), W'(cur.n));
                        chk("tms_seq", obs_tms, cur.tms);
                        chk("tdi_seq", obs_tdi, cur.tdi);
                        chk("tick_stable", W'(stab_err), W'(0));
                        chk("tck_low_at_rsp", W'(tck_o), W'(0));
                    end
                end else begin
                    chk("rsp_data_held", W'(bus.rsp_data), cur.rsp);
                    chk("cmd_ready_in_resp", W'(bus.cmd_ready), W'(0));
                    chk("busy_in_resp", W'(busy), W'(1));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_tck"}, W'(tck_o), W'(0));
        chk({tag, "_tms"}, W'(tms_o), W'(1));
        chk({tag, "_tdi"}, W'(tdi_o), W'(0));
        chk({tag, "_cmd_ready"}, W'(bus.cmd_ready), W'(1));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_rsp_valid"}, W'(bus.rsp_valid), W'(0));
        chk({tag, "_rsp_data"}, W'(bus.rsp_data), W'(0));
    endtask

    task automatic issue(input logic [1:0] typ, input int len, input logic [ML-1:0] data,
                         input int hold, input int abort_at, input bit junk);
        int t;
        int w;
        w = 0;
        while (!bus.cmd_ready && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk("wait_cmd_ready", W'(w >= 4000), W'(0));
        rsp_hold      = hold;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = typ;
        bus.cmd_len   = LWB'(len);
        bus.cmd_data  = data;
        t = cyc;
        exp_q.push_back(model(typ, len, data, t));
        @(negedge clk);
        chk("busy_after_accept", W'(busy), W'(1));
        chk("ready_after_accept", W'(bus.cmd_ready), W'(0));
        // Extra command offered while busy must be ignored.
        bus.cmd_valid = junk;
        bus.cmd_type  = 2'($urandom);
        bus.cmd_len   = LWB'($urandom_range(1, 20));
        bus.cmd_data  = {ML{1'b1}};
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            trst = 1'b1;
            bus.cmd_valid = 1'b0;
            void'(exp_q.pop_back());
            @(negedge clk);
            check_reset_state("abort");
            trst = 1'b0;
        end else begin
            w = 0;
            while (!bus.rsp_valid && w < 5000) begin
                @(negedge clk);
                w++;
            end
            bus.cmd_valid = 1'b0;
            chk("wait_rsp_valid", W'(w >= 5000), W'(0));
        end
    endtask

    function automatic logic [ML-1:0] rand_data();
        logic [ML-1:0] d;
        for (int k = 0; k < ML / 32; k++) d[k * 32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [ML-1:0] d;
        int            r;
        int            len;
        n_chk = 0;
        n_pass = 0;
        rsp_hold = 0;
        trst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'd0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        trst = 1'b0;
        @(negedge clk);

        issue(2'd0, 0, '0, 0, 0, 0);
        d = '0; d[1:0] = 2'b10;
        issue(2'd1, 2, d, 0, 0, 1);
        d = '0; d[7:0] = 8'hA5;
        issue(2'd2, 8, d, 1, 0, 0);
        d = '0; d[0] = 1'b1;
        issue(2'd2, 75, d, 0, 0, 1);
        issue(2'd2, 0, rand_data(), 0, 0, 0);
        issue(2'd2, ML + 5, rand_data(), 2, 0, 0);
        issue(2'd1, ML, rand_data(), 10, 0, 1);
        issue(2'd3, 17, rand_data(), 0, 0, 0);
        issue(2'd2, 40, rand_data(), 0, 3 * 2 * H + 10, 0);
        issue(2'd0, 0, '0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0) len = 0;
            else if (r == 1) len = ML + int'($urandom_range(0, 4));
            else len = int'($urandom_range(1, 48));
            issue(2'($urandom), len, rand_data(), int'($urandom_range(0, 3)), 0,
                  1'($urandom));
        end
        issue(2'd1, 5, rand_data(), 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

Command-driven JTAG master that generates the TCK/TMS/TDI waveforms for the boundary-scan top level and captures its TDO. It sits directly upstream of the TAP pins of that top level: `tck_o`, `tms_o` and `tdi_o` drive its TCK, TMS and TDI inputs, and `tdo_i` is its TDO. It accepts one scan command at a time (TAP reset, IR scan or DR scan). For each command it walks the TAP state machine from Run-Test/Idle, shifts the payload LSB first, returns to Run-Test/Idle and returns the captured TDO bits.

## Interface
Parameters:
- `MAX_LEN`, default 320: maximum scan length in bits. It must cover the 75-cell boundary chain plus the internal scan chain.
- `HALF`, default 1: CK cycles per TCK half-period (≥1). TCK period = 2·HALF CK cycles.
- `LW`, default $clog2(MAX_LEN+1): width of the length field.

Ports:
- `CK` in 1: system clock. The only clock.
- `TRST` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_type` in 2: 0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = reserved (treated as 0).
- `cmd_len` in LW: number of bits to shift.
- `cmd_data` in MAX_LEN: TDI payload; bit 0 is shifted first.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_data` out MAX_LEN: captured TDO bits; bit i is the bit sampled on shift tick i.
- `busy` out 1: a command is in progress.
- `tck_o` out 1: test clock to the DUT.
- `tms_o` out 1: test mode select to the DUT.
- `tdi_o` out 1: test data in to the DUT.
- `tdo_i` in 1: test data out from the DUT, synchronous to CK.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On accept, latch type, length and data; go to HEAD.
  - HEAD: emit the TMS header sequence.
  - SHIFT: emit payload ticks.
  - TAIL: emit the TMS trailer sequence.
  - RESP: hold `rsp_valid`=1; on `rsp_ready`, go to IDLE.
- A "tick" is one full TCK period. During each tick, TMS and TDI are set at the start of the low phase, and TCK rises at mid-tick.
- TMS sequences (the DUT TAP starts in Run-Test/Idle, except for reset):
  - Reset: TMS = 1,1,1,1,1,0 (6 ticks). No SHIFT or TAIL phase; `rsp_data` = 0.
  - IR scan: header 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR), then `len` shift ticks, then trailer 1,0 (Update-IR, Idle). Total len+6 ticks.
  - DR scan: header 1,0,0 (Select-DR, Capture-DR, Shift-DR), then `len` shift ticks, then trailer 1,0. Total len+5 ticks.
- Shift ticks:
  - `tdi_o` = data[i] on tick i.
  - TMS = 0, except on the last shift tick, where TMS = 1 (exit to Exit1).
- `tdo_i` is sampled on the CK edge that raises `tck_o` during shift ticks only. The sampled bit is stored at index i.
- `tdi_o` = 0 outside shift ticks.
- Length rules:
  - `len`=0 on a scan is treated as 1.
  - `len` > MAX_LEN is clamped to MAX_LEN.
  - `rsp_data` bits at index ≥ effective len are 0.
- Software must issue a reset command first after `TRST`. The master itself does not track DUT TAP state.

## Timing
- Reset values:
  - `tck_o`=0, `tms_o`=1, `tdi_o`=0.
  - `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0.
  - State = IDLE.
- Accept at edge t:
  - `busy`=1 and `cmd_ready`=0 from t+1.
  - First tick starts at t+1 with `tck_o`=0 and the first TMS value.
- Per tick: `tck_o` is low for HALF cycles, then high for HALF cycles. TMS and TDI are stable for the whole tick.
- After the last tick's high phase, `tck_o` returns to 0 and `rsp_valid`=1 in the same cycle. This is N·2·HALF cycles after t+1, where N = total tick count.
- `busy` stays 1 until the response handshake.
- `cmd_ready` stays 0 while in RESP. A new command is accepted no earlier than the cycle after `rsp_valid && rsp_ready`.
- `rsp_data` is stable while `rsp_valid`=1.
- `cmd_valid` during a busy period is ignored; no queuing.
- `TRST` mid-operation aborts immediately to reset values. `rsp_valid` is dropped and the partial capture is discarded.

## Test plan
- Reset command, HALF=1:
  - Expect 12 CK cycles of TCK (6 rising edges) with TMS=1,1,1,1,1,0.
  - `rsp_valid` rises 12 cycles after the accept+1 cycle.
  - `rsp_data`=0.
- IR scan, len=2, data=2'b10, with the DUT connected:
  - Expect TMS=1,1,0,0,0,1,1,0 (8 ticks).
  - TDI=0 then 1 on the shift ticks.
  - DUT ir1/ir2 updated to the bypass/boundary encoding.
  - `rsp_data`[1:0] equals the DUT's IR capture value.
- DR scan through bypass, len=8, data=8'hA5:
  - `rsp_data`[7:0]=8'h4A: one-bit delay through the bypass flop, with the first captured bit from the bypass reset value 0.
  - Ticks = 13.
- Boundary DR scan, len=75:
  - Drive a pattern with `g89_in`=1 and all other inputs 0, and scan.
  - Expect captured bit 0 = 1.
  - The payload appears on the DUT outputs after Update-DR (bs_en=1).
- Clamping:
  - DR scan with len=0 → exactly 1 shift tick.
  - len=MAX_LEN+5 → MAX_LEN shift ticks.
  - Upper `rsp_data` bits beyond the effective len = 0.
- Abort and backpressure:
  - Assert `TRST` mid-SHIFT → next cycle `tck_o`=0, `tms_o`=1, `busy`=0, `cmd_ready`=1.
  - Separately, hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_data` stay held, and `cmd_ready` stays 0.
